// File: rtl/seg7_scan_capture.sv
`default_nettype none
// ============================================================================
//  Module      : seg7_scan_capture
//  Description : Read-back receiver for a multiplexed 8-digit seven-segment
//                bus. Waits for each digit selection to dwell, decodes the
//                glyph and stores it in an 8-slot frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg7_scan_capture #(
    parameter int   MIN_DWELL = 16,
    parameter logic SYNC_RST  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  dig_in,
    input  logic [7:0]  seg_in,
    output logic [39:0] frame_o,
    output logic [7:0]  dp_o,
    output logic        frame_done,
    output logic [7:0]  glitch_cnt
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_TRACK   = 2'd1;
    localparam logic [1:0] c_ST_HELD    = 2'd2;
    localparam logic [7:0] c_DWELL_LAST = 8'(MIN_DWELL - 1);
    localparam logic [4:0] c_CODE_BLANK = 5'h11;
    localparam logic [7:0] c_SYNC_INIT  = {8{SYNC_RST}};

    // ------------------------------------------------------------------
    // Input synchronizers
    // ------------------------------------------------------------------
    logic [7:0] r_sd_meta;
    logic [7:0] r_sd;
    logic [7:0] r_ss_meta;
    logic [7:0] r_ss;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sd_meta <= c_SYNC_INIT;
            r_sd      <= c_SYNC_INIT;
            r_ss_meta <= c_SYNC_INIT;
            r_ss      <= c_SYNC_INIT;
        end else begin
            r_sd_meta <= dig_in;
            r_sd      <= r_sd_meta;
            r_ss_meta <= seg_in;
            r_ss      <= r_ss_meta;
        end
    end

    // ------------------------------------------------------------------
    // Tracker status
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    logic [1:0] w_state_next;
    logic [7:0] r_hd;
    logic [7:0] r_hs;
    logic [7:0] r_cnt;

    logic [7:0] w_dig_act;
    logic       w_valid;
    logic       w_same_dig;
    logic       w_same_seg;
    logic       w_dwell_done;

    // A legal selection has exactly one digit line pulled low.
    assign w_dig_act    = ~r_sd;
    assign w_valid      = (w_dig_act != 8'd0) && ((w_dig_act & (w_dig_act - 8'd1)) == 8'd0);
    assign w_same_dig   = (r_sd == r_hd);
    assign w_same_seg   = (r_ss == r_hs);
    assign w_dwell_done = (r_cnt == c_DWELL_LAST);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_valid) begin
                    w_state_next = c_ST_TRACK;
                end
            end
            c_ST_TRACK: begin
                if (!w_valid) begin
                    w_state_next = c_ST_IDLE;
                end else if (w_same_dig && w_same_seg && w_dwell_done) begin
                    w_state_next = c_ST_HELD;
                end else begin
                    w_state_next = c_ST_TRACK;
                end
            end
            c_ST_HELD: begin
                if (!w_valid) begin
                    w_state_next = c_ST_IDLE;
                end else if (!w_same_dig || !w_same_seg) begin
                    w_state_next = c_ST_TRACK;
                end else begin
                    w_state_next = c_ST_HELD;
                end
            end
            default: begin
                w_state_next = c_ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: control outputs
    // ------------------------------------------------------------------
    logic w_load;
    logic w_inc;
    logic w_capture;
    logic w_glitch;

    always_comb begin
        w_load    = 1'b0;
        w_inc     = 1'b0;
        w_capture = 1'b0;
        w_glitch  = 1'b0;
        case (r_state)
            c_ST_IDLE: begin
                w_load = w_valid;
            end
            c_ST_TRACK: begin
                if (w_valid) begin
                    if (!w_same_dig) begin
                        w_load = 1'b1;
                    end else if (!w_same_seg) begin
                        // Segments moved under a steady digit before the dwell finished.
                        w_load   = 1'b1;
                        w_glitch = 1'b1;
                    end else if (w_dwell_done) begin
                        w_capture = 1'b1;
                    end else begin
                        w_inc = 1'b1;
                    end
                end
            end
            c_ST_HELD: begin
                w_load = w_valid && (!w_same_dig || !w_same_seg);
            end
            default: begin
                w_load = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Held value and dwell counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hd  <= 8'hFF;
            r_hs  <= 8'hFF;
            r_cnt <= 8'd0;
        end else if (w_load) begin
            r_hd  <= r_sd;
            r_hs  <= r_ss;
            r_cnt <= 8'd0;
        end else if (w_inc) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Glitch counter
    // ------------------------------------------------------------------
    logic [7:0] r_glitch;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_glitch <= 8'd0;
        end else if (w_glitch && (r_glitch != 8'hFF)) begin
            r_glitch <= r_glitch + 8'd1;
        end
    end

    // ------------------------------------------------------------------
    // Glyph decode and slot index
    // ------------------------------------------------------------------
    function automatic logic [4:0] f_decode(input logic [6:0] i_seg);
        logic [4:0] v_code;
        case (i_seg)
            7'h40:   v_code = 5'h00;
            7'h79:   v_code = 5'h01;
            7'h24:   v_code = 5'h02;
            7'h30:   v_code = 5'h03;
            7'h19:   v_code = 5'h04;
            7'h12:   v_code = 5'h05;
            7'h02:   v_code = 5'h06;
            7'h78:   v_code = 5'h07;
            7'h00:   v_code = 5'h08;
            7'h10:   v_code = 5'h09;
            7'h08:   v_code = 5'h0A;
            7'h03:   v_code = 5'h0B;
            7'h46:   v_code = 5'h0C;
            7'h21:   v_code = 5'h0D;
            7'h06:   v_code = 5'h0E;
            7'h0E:   v_code = 5'h0F;
            7'h0C:   v_code = 5'h10;
            7'h7F:   v_code = c_CODE_BLANK;
            default: v_code = 5'h1F;
        endcase
        return v_code;
    endfunction

    logic [4:0] w_code;
    logic [2:0] w_slot;

    assign w_code = f_decode(r_hs[6:0]);

    // r_hd is one-hot-low whenever a capture fires, so a simple scan suffices.
    always_comb begin
        w_slot = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (!r_hd[i]) begin
                w_slot = 3'(i);
            end
        end
    end

    // ------------------------------------------------------------------
    // Frame storage, decimal points and completion tracking
    // ------------------------------------------------------------------
    logic [39:0] r_frame;
    logic [7:0]  r_dp;
    logic [7:0]  r_mask;
    logic        r_done;
    logic [7:0]  w_mask_set;

    assign w_mask_set = r_mask | (8'd1 << w_slot);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame <= {8{c_CODE_BLANK}};
            r_dp    <= 8'd0;
        end else if (w_capture) begin
            for (int i = 0; i < 8; i++) begin
                if (w_slot == 3'(i)) begin
                    r_frame[5*i +: 5] <= w_code;
                end
            end
            r_dp[w_slot] <= ~r_hs[7];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask <= 8'd0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_capture) begin
                if (w_mask_set == 8'hFF) begin
                    r_mask <= 8'd0;
                    r_done <= 1'b1;
                end else begin
                    r_mask <= w_mask_set;
                end
            end
        end
    end

    assign frame_o    = r_frame;
    assign dp_o       = r_dp;
    assign frame_done = r_done;
    assign glitch_cnt = r_glitch;

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_capture.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg7_scan_capture
//  Description : Scoreboard bench for seg7_scan_capture with a run-length
//                reference model of the dwell/capture behaviour.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_capture;
    localparam int M = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  dig_in;
    logic [7:0]  seg_in;
    logic [39:0] frame_o;
    logic [7:0]  dp_o;
    logic        frame_done;
    logic [7:0]  glitch_cnt;

    seg7_scan_capture #(.MIN_DWELL(M), .SYNC_RST(1'b1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .dig_in     (dig_in),
        .seg_in     (seg_in),
        .frame_o    (frame_o),
        .dp_o       (dp_o),
        .frame_done (frame_done),
        .glitch_cnt (glitch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [39:0] frame;
        logic [7:0]  dp;
        logic        done;
        logic [7:0]  glitch;
    } snap_t;

    snap_t exp_q[$];
    int    total = 0;
    int    bad = 0;
    int    done_seen = 0;

    // Active-low glyphs for hex digits 0..F, index = code
    logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // ---------------- reference model ----------------
    logic [15:0] m_s1, m_s2, m_prev;
    int          m_run;
    logic [4:0]  m_code [8];
    logic [7:0]  m_dp, m_mask, m_glitch;
    logic        m_done;

    function automatic logic [4:0] ref_decode(input logic [6:0] s);
        for (int i = 0; i < 16; i++) if (glyph[i] == s) return 5'(i);
        if (s == 7'h0C) return 5'h10;
        if (s == 7'h7F) return 5'h11;
        return 5'h1F;
    endfunction

    task automatic m_reset();
        m_s1 = 16'hFFFF; m_s2 = 16'hFFFF; m_prev = 16'hFFFF; m_run = 0;
        for (int i = 0; i < 8; i++) m_code[i] = 5'h11;
        m_dp = 8'd0; m_mask = 8'd0; m_glitch = 8'd0; m_done = 1'b0;
    endtask

    // One clock edge: the tracker sees the value that entered the pins two edges ago.
    task automatic m_step(input logic [15:0] pin);
        logic [15:0] obs;
        logic        cap;
        int          slot;
        obs = m_s2; m_s2 = m_s1; m_s1 = pin;
        m_done = 1'b0; cap = 1'b0; slot = 0;
        if ($countones(~obs[15:8]) != 1) begin
            m_run = 0;
        end else begin
            if (m_run == 0 || obs != m_prev) begin
                if (m_run > 0 && m_run <= M && obs[15:8] == m_prev[15:8] && m_glitch != 8'hFF)
                    m_glitch = m_glitch + 8'd1;
                m_run = 1;
            end else begin
                if (m_run == M) cap = 1'b1;
                if (m_run < M + 2) m_run++;
            end
        end
        m_prev = obs;
        if (cap) begin
            for (int i = 0; i < 8; i++) if (!obs[8+i]) slot = i;
            m_code[slot] = ref_decode(obs[6:0]);
            m_dp[slot]   = ~obs[7];
            m_mask[slot] = 1'b1;
            if (m_mask == 8'hFF) begin
                m_done = 1'b1;
                m_mask = 8'd0;
            end
        end
    endtask

    function automatic snap_t snapshot();
        snap_t s;
        for (int i = 0; i < 8; i++) s.frame[5*i +: 5] = m_code[i];
        s.dp = m_dp; s.done = m_done; s.glitch = m_glitch;
        return s;
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input logic [7:0] d, input logic [7:0] s);
        dig_in = d; seg_in = s;
        @(posedge clk);
        m_step({d, s});
        exp_q.push_back(snapshot());
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", name, act, want);
        end
    endtask

    function automatic logic [4:0] slot_of(input int i);
        return frame_o[5*i +: 5];
    endfunction

    // ---------------- monitor ----------------
    initial begin
        snap_t e;
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) done_seen++;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if ({frame_o, dp_o, frame_done, glitch_cnt} !== e) begin
                    bad++;
                    $display("FAIL scoreboard t=%0t got frame=%h dp=%h done=%b gl=%0d want frame=%h dp=%h done=%b gl=%0d",
                             $time, frame_o, dp_o, frame_done, glitch_cnt, e.frame, e.dp, e.done, e.glitch);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        logic [39:0] blank_frame;
        logic [39:0] scan_frame;
        logic [7:0]  scan_seg [8];
        logic [7:0]  d, s;
        int          d0, len;

        blank_frame = {8{5'h11}};
        scan_frame  = {5'h0C, 5'h10, 5'h0E, 5'h01, 5'h06, 5'h06, 5'h0A, 5'h10};
        scan_seg    = '{8'h8C, 8'h88, 8'h82, 8'h82, 8'hF9, 8'h86, 8'h8C, 8'hC6};

        rst_n = 1'b0; dig_in = 8'hFF; seg_in = 8'hFF;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_frame", frame_o, blank_frame);
        chk("reset_dp", dp_o, 0);
        chk("reset_done", frame_done, 0);
        chk("reset_glitch", glitch_cnt, 0);
        @(negedge clk); #2 rst_n = 1'b1;

        // Invalid selections never capture
        for (int i = 0; i < 100; i++) cyc(($urandom_range(0, 1) != 0) ? 8'hFC : 8'hFF, 8'($urandom));
        chk("invalid_frame", frame_o, blank_frame);
        chk("invalid_glitch", glitch_cnt, 0);
        chk("invalid_done", done_seen, 0);

        // Dwell threshold on slot 0
        repeat (M) cyc(8'hFE, 8'hF9);
        repeat (6) cyc(8'hFF, 8'hFF);
        chk("short_dwell_slot0", slot_of(0), 5'h11);
        repeat (M + 3) cyc(8'hFE, 8'hF9);
        repeat (6) cyc(8'hFF, 8'hFF);
        chk("full_dwell_slot0", slot_of(0), 5'h01);

        // Two full scans
        for (int sc = 0; sc < 2; sc++) begin
            d0 = done_seen;
            for (int i = 0; i < 8; i++) repeat (40) cyc(~(8'd1 << i), scan_seg[i]);
            chk("scan_done_count", done_seen - d0, 1);
            chk("scan_frame", frame_o, scan_frame);
        end

        // Segment flip under steady digit 2
        repeat (5) cyc(8'hFB, 8'hB0);
        for (int i = 1; i <= M + 6; i++) begin
            cyc(8'hFB, 8'h80);
            if (i == M + 2) chk("flip_not_yet", slot_of(2), 5'h06);
            if (i == M + 3) chk("flip_captured", slot_of(2), 5'h08);
        end
        chk("flip_glitch", glitch_cnt, 1);

        // Unknown glyph with dp, then glitch saturation
        repeat (20) cyc(8'hEF, 8'h36);
        chk("unknown_slot4", slot_of(4), 5'h1F);
        chk("unknown_dp4", dp_o[4], 1);
        for (int i = 0; i < 300; i++) cyc(8'hEF, (i % 2 != 0) ? 8'h37 : 8'h36);
        chk("glitch_saturate", glitch_cnt, 8'hFF);

        // Asynchronous reset mid-frame
        for (int i = 0; i < 5; i++) repeat (25) cyc(~(8'd1 << i), {1'b1, glyph[i]});
        repeat (8) cyc(8'hDF, 8'h92);
        @(negedge clk); #2 rst_n = 1'b0; dig_in = 8'hFF; seg_in = 8'hFF;
        #1;
        chk("async_rst_frame", frame_o, blank_frame);
        chk("async_rst_dp", dp_o, 0);
        chk("async_rst_done", frame_done, 0);
        chk("async_rst_glitch", glitch_cnt, 0);
        m_reset();
        d0 = done_seen;
        repeat (3) @(posedge clk);
        @(negedge clk); #2 rst_n = 1'b1;
        for (int i = 3; i < 8; i++) repeat (25) cyc(~(8'd1 << i), {1'b0, glyph[i]});
        chk("post_rst_no_done", done_seen - d0, 0);
        for (int i = 0; i < 3; i++) repeat (25) cyc(~(8'd1 << i), {1'b1, glyph[i+8]});
        chk("post_rst_done", done_seen - d0, 1);

        // Randomized traffic
        d = 8'hFE;
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 9) < 3) d = d;
            else if ($urandom_range(0, 9) < 8) d = ~(8'd1 << $urandom_range(0, 7));
            else d = 8'($urandom);
            case ($urandom_range(0, 9))
                0:       s = {1'($urandom), 7'h0C};
                1:       s = {1'($urandom), 7'h7F};
                2:       s = 8'($urandom);
                default: s = {1'($urandom), glyph[$urandom_range(0, 15)]};
            endcase
            len = $urandom_range(1, 30);
            repeat (len) cyc(d, s);
        end

        repeat (4) cyc(8'hFF, 8'hFF);
        @(negedge clk); #1;
        chk("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
